ofdm_symbol_timer: RTL and testbench

//   Frame/symbol timing generator for the OFDM receiver. A single sync pulse from the

---
 rtl/ofdm_symbol_timer.sv | 193 +++++++++++++++++++
 tb/tb_ofdm_symbol_timer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ofdm_symbol_timer.sv
// OFDM frame/symbol timing generator.
// A sync pulse from the preamble detector starts a frame of NSYM symbols, each
// NCP+NFFT samples long. Every output describes the en-qualified input sample
// seen on the previous cycle: valid, SOP/EOP, CP/data split, indices and
// frame-level status. An accepted mid-frame resync restarts the frame and
// reports whether it landed on a symbol boundary.
module ofdm_symbol_timer #(
    parameter  int NFFT = 1024,
    parameter  int NCP  = 32,
    parameter  int NSYM = 32,
    localparam int SLEN = NFFT + NCP,
    localparam int CW   = $clog2(SLEN),
    localparam int SW   = ($clog2(NSYM) > 0) ? $clog2(NSYM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_sync_in,
    input  logic          i_resync_en,
    output logic          o_out_valid,
    output logic          o_sym_sop,
    output logic          o_sym_eop,
    output logic          o_cp_flag,
    output logic          o_data_flag,
    output logic [CW-1:0] o_samp_idx,
    output logic [SW-1:0] o_sym_idx,
    output logic          o_frame_active,
    output logic          o_frame_done,
    output logic          o_sync_err
);

    localparam logic [CW-1:0] LAST_SAMP = CW'(SLEN - 1);
    localparam logic [SW-1:0] LAST_SYM  = SW'(NSYM - 1);
    localparam logic [CW-1:0] NCP_C     = CW'(NCP);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Control state. r_nsamp/r_nsym hold the position the next en-sample will
    // take if no resync is accepted.
    state_t        r_state;
    logic [CW-1:0] r_nsamp;
    logic [SW-1:0] r_nsym;

    // Registered outputs.
    logic          r_vld_p1;
    logic          r_sop_p1;
    logic          r_eop_p1;
    logic          r_cp_p1;
    logic          r_data_p1;
    logic [CW-1:0] r_samp_p1;
    logic [SW-1:0] r_sym_p1;
    logic          r_fact_p1;
    logic          r_done_p1;
    logic          r_err_p1;

    // Next-state / per-sample decode.
    state_t        w_state_nxt;
    logic [CW-1:0] w_nsamp_nxt;
    logic [SW-1:0] w_nsym_nxt;
    logic          w_active;
    logic [CW-1:0] w_pos_samp;
    logic [SW-1:0] w_pos_sym;
    logic          w_err;
    logic          w_sop;
    logic          w_eop;
    logic          w_in_cp;
    logic          w_done;

    // State and position counters; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_nsamp <= '0;
            r_nsym  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_nsamp <= w_nsamp_nxt;
            r_nsym  <= w_nsym_nxt;
        end
    end

    // Next state, position of the current sample and its flags.
    always_comb begin
        w_state_nxt = r_state;
        w_nsamp_nxt = r_nsamp;
        w_nsym_nxt  = r_nsym;
        w_active    = 1'b0;
        w_pos_samp  = '0;
        w_pos_sym   = '0;
        w_err       = 1'b0;
        w_sop       = 1'b0;
        w_eop       = 1'b0;
        w_in_cp     = 1'b0;
        w_done      = 1'b0;

        if (i_en) begin
            case (r_state)
                S_IDLE: begin
                    if (i_sync_in) begin
                        // Current sample is sample 0 of symbol 0.
                        w_active    = 1'b1;
                        w_state_nxt = S_RUN;
                        w_nsamp_nxt = CW'(1);
                        w_nsym_nxt  = '0;
                    end
                end
                S_RUN: begin
                    w_active = 1'b1;
                    if (i_sync_in && i_resync_en) begin
                        // Restart; misaligned only if we were mid-symbol.
                        w_err       = (r_nsamp != '0);
                        w_nsamp_nxt = CW'(1);
                        w_nsym_nxt  = '0;
                    end else begin
                        w_pos_samp = r_nsamp;
                        w_pos_sym  = r_nsym;
                        if (r_nsamp == LAST_SAMP) begin
                            w_nsamp_nxt = '0;
                            if (r_nsym == LAST_SYM) begin
                                w_nsym_nxt  = '0;
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_nsym_nxt = r_nsym + SW'(1);
                            end
                        end else begin
                            w_nsamp_nxt = r_nsamp + CW'(1);
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        if (w_active) begin
            w_sop   = (w_pos_samp == '0);
            w_eop   = (w_pos_samp == LAST_SAMP);
            w_in_cp = (w_pos_samp < NCP_C);
            w_done  = w_eop && (w_pos_sym == LAST_SYM);
        end
    end

    // Output register: pulses clear on en=0 gaps, indices and frame_active hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_sop_p1  <= 1'b0;
            r_eop_p1  <= 1'b0;
            r_cp_p1   <= 1'b0;
            r_data_p1 <= 1'b0;
            r_samp_p1 <= '0;
            r_sym_p1  <= '0;
            r_fact_p1 <= 1'b0;
            r_done_p1 <= 1'b0;
            r_err_p1  <= 1'b0;
        end else if (i_en) begin
            r_vld_p1  <= 1'b1;
            r_sop_p1  <= w_sop;
            r_eop_p1  <= w_eop;
            r_cp_p1   <= w_active && w_in_cp;
            r_data_p1 <= w_active && !w_in_cp;
            r_fact_p1 <= w_active;
            r_done_p1 <= w_done;
            r_err_p1  <= w_err;
            if (w_active) begin
                r_samp_p1 <= w_pos_samp;
                r_sym_p1  <= w_pos_sym;
            end
        end else begin
            r_vld_p1  <= 1'b0;
            r_sop_p1  <= 1'b0;
            r_eop_p1  <= 1'b0;
            r_cp_p1   <= 1'b0;
            r_data_p1 <= 1'b0;
            r_done_p1 <= 1'b0;
            r_err_p1  <= 1'b0;
        end
    end

    assign o_out_valid    = r_vld_p1;
    assign o_sym_sop      = r_sop_p1;
    assign o_sym_eop      = r_eop_p1;
    assign o_cp_flag      = r_cp_p1;
    assign o_data_flag    = r_data_p1;
    assign o_samp_idx     = r_samp_p1;
    assign o_sym_idx      = r_sym_p1;
    assign o_frame_active = r_fact_p1;
    assign o_frame_done   = r_done_p1;
    assign o_sync_err     = r_err_p1;

endmodule

// File: tb/tb_ofdm_symbol_timer.sv
// Directed bench for ofdm_symbol_timer: NFFT=16, NCP=4, NSYM=3 (20-sample
// symbols, 60-sample frames) plus a default-parameter instance for symbol
// geometry.
module tb_ofdm_symbol_timer;

    logic clk = 1'b0;
    logic rst;
    logic en, sync, rs;
    logic ov, sop, eop, cp, dat, fa, done, err;
    logic [4:0] samp;
    logic [1:0] sym;

    logic d_en, d_sync;
    logic d_ov, d_sop, d_eop, d_cp, d_dat, d_fa, d_done, d_err;
    logic [10:0] d_samp;
    logic [4:0]  d_sym;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ofdm_symbol_timer #(.NFFT(16), .NCP(4), .NSYM(3)) u_dut (
        .clk(clk), .rst(rst), .i_en(en), .i_sync_in(sync), .i_resync_en(rs),
        .o_out_valid(ov), .o_sym_sop(sop), .o_sym_eop(eop), .o_cp_flag(cp),
        .o_data_flag(dat), .o_samp_idx(samp), .o_sym_idx(sym),
        .o_frame_active(fa), .o_frame_done(done), .o_sync_err(err)
    );

    ofdm_symbol_timer u_def (
        .clk(clk), .rst(rst), .i_en(d_en), .i_sync_in(d_sync), .i_resync_en(1'b0),
        .o_out_valid(d_ov), .o_sym_sop(d_sop), .o_sym_eop(d_eop), .o_cp_flag(d_cp),
        .o_data_flag(d_dat), .o_samp_idx(d_samp), .o_sym_idx(d_sym),
        .o_frame_active(d_fa), .o_frame_done(d_done), .o_sync_err(d_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {out_valid, sop, eop, cp, data, frame_active, frame_done, sync_err}
    function automatic logic [7:0] flags();
        return {ov, sop, eop, cp, dat, fa, done, err};
    endfunction

    task automatic step(input logic e, input logic s);
        @(negedge clk);
        en   = e;
        sync = s;
        @(posedge clk);
        #1;
    endtask

    // Expected output for the n-th sample of an undisturbed frame.
    task automatic exp_pos(input string tag, input int n);
        int sa = n % 20;
        int sy = n / 20;
        logic [7:0] f;
        f = {1'b1, (sa == 0), (sa == 19), (sa < 4), (sa >= 4), 1'b1, (n == 59), 1'b0};
        chk($sformatf("%s[%0d]/flags", tag, n), {24'd0, flags()}, {24'd0, f});
        chk($sformatf("%s[%0d]/samp", tag, n), {27'd0, samp}, sa);
        chk($sformatf("%s[%0d]/sym", tag, n), {30'd0, sym}, sy);
    endtask

    // Frame samples from..to (sync sent at sample 0); optional en=0 gap after each.
    task automatic run(input string tag, input int from, input int to, input bit gap);
        for (int n = from; n <= to; n++) begin
            step(1'b1, (n == 0));
            exp_pos(tag, n);
            if (gap) begin
                step(1'b0, 1'b0);
                chk($sformatf("%s_gap[%0d]/flags", tag, n), {24'd0, flags()}, 32'h04);
                chk($sformatf("%s_gap[%0d]/samp", tag, n), {27'd0, samp}, n % 20);
                chk($sformatf("%s_gap[%0d]/sym", tag, n), {30'd0, sym}, n / 20);
            end
        end
    endtask

    initial begin
        int cnt_cp, cnt_data, cnt_sop;
        rst = 1'b1; en = 1'b0; sync = 1'b0; rs = 1'b0;
        d_en = 1'b0; d_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/flags", {24'd0, flags()}, 32'h00);
        chk("reset/samp", {27'd0, samp}, 0);
        chk("reset/sym", {30'd0, sym}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Free-running en: idle samples, then a full frame, then idle again.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            chk("t1_idle/flags", {24'd0, flags()}, 32'h80);
            chk("t1_idle/samp", {27'd0, samp}, 0);
        end
        run("t1", 0, 59, 1'b0);
        step(1'b1, 1'b0);
        chk("t1_after/flags", {24'd0, flags()}, 32'h80);

        // en toggling: same sequence, indices hold through gaps.
        run("t2", 0, 59, 1'b1);
        step(1'b1, 1'b0);
        chk("t2_after/flags", {24'd0, flags()}, 32'h80);

        // Misaligned resync at sym=1, samp=7.
        rs = 1'b1;
        run("t3a", 0, 26, 1'b0);
        step(1'b1, 1'b1);
        chk("t3_resync/flags", {24'd0, flags()}, 32'hD5);
        chk("t3_resync/samp", {27'd0, samp}, 0);
        chk("t3_resync/sym", {30'd0, sym}, 0);
        run("t3b", 1, 59, 1'b0);
        step(1'b1, 1'b0);
        chk("t3_after/flags", {24'd0, flags()}, 32'h80);

        // Aligned resync where sym=2, samp=0 was expected.
        run("t4a", 0, 39, 1'b0);
        step(1'b1, 1'b1);
        chk("t4_resync/flags", {24'd0, flags()}, 32'hD4);
        chk("t4_resync/sym", {30'd0, sym}, 0);
        run("t4a2", 1, 59, 1'b0);
        // Same point with resync disabled: ignored.
        rs = 1'b0;
        run("t4b", 0, 39, 1'b0);
        step(1'b1, 1'b1);
        exp_pos("t4b_ign", 40);
        run("t4b2", 41, 59, 1'b0);
        step(1'b1, 1'b0);
        chk("t4_after/flags", {24'd0, flags()}, 32'h80);

        // Resync on the last frame sample: no eop/done, restart (expected samp 19 -> err).
        rs = 1'b1;
        run("t5a", 0, 58, 1'b0);
        step(1'b1, 1'b1);
        chk("t5_last/flags", {24'd0, flags()}, 32'hD5);
        chk("t5_last/samp", {27'd0, samp}, 0);
        run("t5b", 1, 59, 1'b0);
        // Sync on the en right after frame_done: clean start.
        step(1'b1, 1'b1);
        exp_pos("t5c", 0);
        run("t5d", 1, 59, 1'b0);

        // Asynchronous reset mid-symbol.
        rs = 1'b0;
        run("t6a", 0, 25, 1'b0);
        @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst/flags", {24'd0, flags()}, 32'h00);
        chk("t6_rst/samp", {27'd0, samp}, 0);
        chk("t6_rst/sym", {30'd0, sym}, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0);
        chk("t6_nosync/flags", {24'd0, flags()}, 32'h80);
        run("t6b", 0, 59, 1'b0);
        @(negedge clk);
        en = 1'b0;

        // Default parameters: 1056-sample symbols, 32 CP, 1024 data.
        cnt_cp = 0; cnt_data = 0; cnt_sop = 0;
        for (int k = 0; k <= 1056; k++) begin
            @(negedge clk);
            d_en   = 1'b1;
            d_sync = (k == 0);
            @(posedge clk);
            #1;
            if (k == 0) begin
                chk("def_first/sop", {31'd0, d_sop}, 1);
            end
            if (k < 1056) begin
                cnt_cp   += int'(d_cp);
                cnt_data += int'(d_dat);
                if (k > 0) cnt_sop += int'(d_sop);
            end else begin
                chk("def_sop1056", {31'd0, d_sop}, 1);
                chk("def_sym1056", {27'd0, d_sym}, 1);
            end
        end
        @(negedge clk);
        d_en = 1'b0;
        chk("def/cp_count", cnt_cp, 32);
        chk("def/data_count", cnt_data, 1024);
        chk("def/sop_inside", cnt_sop, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
